bootmem_loader: RTL and testbench

- Write-side companion to the single-port boot ROM.
- Accepts a byte stream through a valid/ready handshake, for example from a UART or SPI receiver.
- Assembles the bytes little-endian into DATA_WIDTH words and writes them into a single-ported RAM starting at a programmed base address.
- Used to fill boot memory at run time instead of preloading it.

---
 rtl/bootmem_loader.sv | 187 ++++++++++++++++++
 tb/tb_bootmem_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : bootmem_loader
// Purpose  : Write-side companion to the boot ROM. Takes a byte stream over a
//            valid/ready handshake, packs bytes little-endian into DATA_WIDTH
//            words and writes them to a single-ported RAM from a programmed
//            base address. Used to fill boot memory at run time.
// Ports    : clk, resetn (async, active low)
//            start, base_addr, word_count  - load request (IDLE/DONE only)
//            byte_valid, byte_ready, byte_data - byte stream handshake
//            mem_ce, mem_we, mem_addr, mem_din - RAM write port (WRITE only)
//            busy, done, err                - status; err valid while done=1
// Options  : BOOTMEM_LOADER_CHECKSUM_EN adds input expected_sum; the load then
//            fails if the wrapping sum of all written words differs from it.
// Revision : 1.0 - initial release
// ============================================================================
module bootmem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
`ifdef BOOTMEM_LOADER_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] expected_sum,
`endif
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [7:0]            byte_data,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]    C_LAST_IDX = IDX_W'(NB - 1);
  // 2**ADDR_WIDTH at ADDR_WIDTH+2 bits, so base+count can never overflow
  localparam logic [ADDR_WIDTH+1:0] C_DEPTH = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_ONE_WORD = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_err;

  logic [ADDR_WIDTH+1:0] w_end;
  logic                  w_range_bad;
  logic                  w_zero_cnt;
  logic                  w_last_word;
  logic                  w_zero_err;
  logic                  w_final_err;

  assign w_end       = {2'b00, base_addr} + {1'b0, word_count};
  assign w_range_bad = (w_end > C_DEPTH);
  assign w_zero_cnt  = (word_count == '0);
  assign w_last_word = (r_remain == C_ONE_WORD);

`ifdef BOOTMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] r_expected;
  logic [DATA_WIDTH-1:0] w_sum_nxt;

  assign w_sum_nxt   = r_sum + r_word;
  // An empty load has a sum of zero
  assign w_zero_err  = (expected_sum != '0);
  // Include the word being written now, since r_sum lags by one write
  assign w_final_err = (w_sum_nxt != r_expected);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sum      <= '0;
      r_expected <= '0;
    end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
      r_sum      <= '0;
      r_expected <= expected_sum;
    end else if (r_state == S_WRITE) begin
      r_sum      <= w_sum_nxt;
    end
  end
`else
  assign w_zero_err  = 1'b0;
  assign w_final_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    byte_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          if (w_zero_cnt || w_range_bad) w_state_nxt = S_DONE;
          else                           w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && r_idx == C_LAST_IDX) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_ce      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = r_addr;
        mem_din     = r_word;
        w_state_nxt = w_last_word ? S_DONE : S_COLLECT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign err = r_err;

  // Datapath: byte assembly, address/count tracking, error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx    <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx <= '0;
            if (w_zero_cnt) begin
              r_err <= w_zero_err;
            end else if (w_range_bad) begin
              r_err <= 1'b1;
            end else begin
              r_addr   <= base_addr;
              r_remain <= word_count;
              r_err    <= 1'b0;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            r_word[8*r_idx +: 8] <= byte_data;
            r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
          end
        end
        S_WRITE: begin
          // After the final word r_addr may step past the top; it is never used
          r_addr   <= r_addr + ADDR_WIDTH'(1);
          r_remain <= r_remain - C_ONE_WORD;
          if (w_last_word) r_err <= w_final_err;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bootmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bootmem_loader
// Purpose  : Self-checking bench for bootmem_loader. A load-level model turns
//            each request into a list of expected (address, word) writes and
//            an expected error flag; a per-cycle monitor checks the RAM port
//            against that list, and the driver checks status and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bootmem_loader;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, mem_ce, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
`ifdef BOOTMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] expected_sum = '0;
`endif

  bootmem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
`ifdef BOOTMEM_LOADER_CHECKSUM_EN
    .expected_sum (expected_sum),
`endif
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of writes the model says must appear, in order
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  int            we_count = 0;
  int            last_we_cyc = 0;
  logic [DW-1:0] last_we_din = '0;
  int            start_cyc = 0;
  logic [7:0]    fixed_bytes[0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor of the RAM port and status consistency
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_we) begin
        we_count++;
        last_we_cyc = cyc;
        last_we_din = mem_din;
        chk("we_ce", mem_ce, 1);
        chk("we_ready_low", byte_ready, 0);
        chk("we_busy", busy, 1);
        chk("write_expected", q_addr.size() != 0, 1);
        if (q_addr.size() != 0) begin
          chk("wr_addr", mem_addr, q_addr.pop_front());
          chk("wr_data", mem_din, q_data.pop_front());
        end
      end else begin
        chk("idle_ce", mem_ce, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_din", mem_din, 0);
      end
      if (byte_ready) chk("ready_busy", busy, 1);
      if (done) chk("done_quiet", {busy, byte_ready}, 0);
    end
  end

  // Issue one load request and feed its bytes.
  // gap: 0 = valid held high, 1 = valid low every other cycle, 2 = random gaps.
  // abort_at >= 0: drop resetn after that many bytes and discard the load.
  task automatic run_load(input logic [AW-1:0] base, input int cnt, input int gap,
                          input bit fixed, input bit mid_start, input int abort_at,
                          input logic [DW-1:0] esum);
    logic [7:0]    bytes[$];
    logic [7:0]    x;
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    bit            exp_err;
    bit            v;
    bit            pulsed;
    int            n, t;
    sum = '0;
    if (cnt > 0 && int'(base) + cnt <= (1 << AW)) begin
      for (int k = 0; k < cnt; k++) begin
        w = '0;
        for (int b = 0; b < NB; b++) begin
          x = fixed ? fixed_bytes[k*NB + b] : 8'($urandom);
          bytes.push_back(x);
          w = w | (DW'(x) << (8 * b));
        end
        q_addr.push_back(AW'(int'(base) + k));
        q_data.push_back(w);
        sum = sum + w;
      end
    end
`ifdef BOOTMEM_LOADER_CHECKSUM_EN
    if (cnt == 0)                         exp_err = (esum != '0);
    else if (int'(base) + cnt > (1 << AW)) exp_err = 1'b1;
    else                                  exp_err = (sum != esum);
    expected_sum = esum;
`else
    if (cnt == 0)                         exp_err = 1'b0;
    else if (int'(base) + cnt > (1 << AW)) exp_err = 1'b1;
    else                                  exp_err = 1'b0;
`endif
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = (AW+1)'(cnt);
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    if (bytes.size() == 0) begin
      chk("quick_done", done, 1);
      chk("quick_err", err, exp_err);
      chk("quick_busy", busy, 0);
      // Offered bytes must not be taken while finished
      byte_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("no_take_ready", byte_ready, 0);
      end
      byte_valid = 1'b0;
      return;
    end
    chk("ready_latency", byte_ready, 1);
    n = 0; t = 0; pulsed = 1'b0;
    while (n < bytes.size()) begin
      if (abort_at >= 0 && n == abort_at) begin
        resetn = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk("arst_ready", byte_ready, 0);
        chk("arst_ce", mem_ce, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_din", mem_din, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        q_addr.delete();
        q_data.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        return;
      end
      if (gap == 1)      v = (t % 2 == 0);
      else if (gap == 2) v = ($urandom_range(0, 2) != 0);
      else               v = 1'b1;
      if (mid_start && !pulsed && n == 3) begin
        start = 1'b1; base_addr = ~base; word_count = (AW+1)'(1); pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      byte_valid = v;
      byte_data  = bytes[n];
      if (v && byte_ready) n++;
      @(negedge clk);
      t++;
      if (t > 40 * cnt * NB + 50) begin
        chk("byte_timeout", n, bytes.size());
        break;
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk("we_latency", mem_we, 1);
    @(negedge clk);
    chk("done_latency", done, 1);
    chk("final_err", err, exp_err);
    chk("final_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_before;
    logic [AW-1:0] rb;
    int rc;
    // Reset state
    @(negedge clk);
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Basic load: one word, valid held high
    fixed_bytes[0] = 8'h97; fixed_bytes[1] = 8'h21; fixed_bytes[2] = 8'h00; fixed_bytes[3] = 8'h00;
    fixed_bytes[4] = 8'h93; fixed_bytes[5] = 8'h81; fixed_bytes[6] = 8'h01; fixed_bytes[7] = 8'h80;
    we_before = we_count;
    run_load(8'h00, 1, 0, 1'b1, 1'b0, -1, 64'h8001819300002197);
    chk("basic_din_literal", last_we_din, 64'h8001819300002197);
    chk("basic_we_from_start", last_we_cyc - start_cyc, 9);
    chk("basic_one_write", we_count - we_before, 1);
    chk("basic_err_literal", err, 0);

    // Two words with valid low every other cycle
    run_load(8'h05, 2, 1, 1'b0, 1'b0, -1, '0);

    // Zero count
    we_before = we_count;
    run_load(8'h10, 0, 0, 1'b0, 1'b0, -1, '0);
    chk("zero_no_write", we_count - we_before, 0);

    // Range error
    run_load(8'hFE, 3, 0, 1'b0, 1'b0, -1, '0);
    chk("range_err_literal", err, 1);
    chk("range_no_write", we_count - we_before, 0);

    // Top-of-memory boundary with a mid-load start, then an immediate restart
    run_load(8'hFE, 2, 0, 1'b0, 1'b1, -1, '0);
    chk("boundary_err_literal", err, 0);
    run_load(8'h40, 1, 2, 1'b0, 1'b0, -1, '0);

    // Reset after three bytes, then a clean load
    run_load(8'h30, 2, 0, 1'b0, 1'b0, 3, '0);
    run_load(8'h30, 1, 0, 1'b0, 1'b0, -1, '0);

    // Randomized loads
    for (int r = 0; r < 8; r++) begin
      rc = $urandom_range(1, 3);
      rb = AW'($urandom_range(0, (1 << AW) - rc));
      run_load(rb, rc, $urandom_range(0, 2), 1'b0, bit'($urandom_range(0, 1)), -1, '0);
    end

`ifdef BOOTMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < 16; i++) fixed_bytes[i] = 8'h00;
    fixed_bytes[0] = 8'h01;
    run_load(8'h20, 1, 0, 1'b1, 1'b0, -1, 64'h1);
    chk("cksum_match_literal", err, 0);
    run_load(8'h20, 1, 0, 1'b1, 1'b0, -1, 64'h2);
    chk("cksum_mismatch_literal", err, 1);
    run_load(8'h00, 0, 0, 1'b0, 1'b0, -1, 64'h5);
    chk("cksum_zero_literal", err, 1);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", q_addr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
